// File: rtl/pitch_pkg.sv
// Shared types for the fundamental-frequency frame sequencer.
// Holds the sequencer state encoding and the packed pitch result word.
package pitch_pkg;
    localparam int FRAME_LEN_DEF = 1024;

    typedef enum logic [2:0] {IDLE, FWD, WAIT, RECOV, REPORT} seq_state_t;

    typedef struct packed {
        logic       timeout;
        logic [7:0] frame_id;
        logic [4:0] bin;
    } pitch_result_t;
endpackage

// File: rtl/frame_position_counter.sv
// Counts FFT beats modulo FRAME_LEN and flags frame boundaries.
// synced rises on the first wrap so a frame cut by reset is never treated as whole.
module frame_position_counter
    import pitch_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic beat,
    output logic synced,
    output logic frame_start,
    output logic frame_end
);
    localparam int PW = $clog2(FRAME_LEN);

    logic [PW-1:0] pos;
    logic          last;

    assign last        = (pos == PW'(FRAME_LEN - 1));
    assign frame_start = beat & (pos == '0);
    assign frame_end   = beat & last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos    <= '0;
            synced <= 1'b0;
        end else if (beat) begin
            pos <= last ? '0 : pos + 1'b1;
            if (last)
                synced <= 1'b1;
        end
    end
endmodule

// File: rtl/fundamental_frame_sequencer.sv
// Gates FFT magnitude frames into the fundamental bin finder one at a time,
// decimating frames and recovering the finder with a reset when it stops answering.
module fundamental_frame_sequencer
    import pitch_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int MAG_W     = 48,
    parameter int TIMEOUT   = 4096,
    parameter int RST_CYC   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       decim,
    input  logic             fft_valid,
    input  logic [MAG_W-1:0] fft_data,
    output logic             fft_ready,
    output logic             fbf_mag_valid,
    output logic [MAG_W-1:0] fbf_mag_data,
    input  logic             fbf_bin_valid,
    input  logic [4:0]       fbf_bin_data,
    output logic             fbf_bin_ready,
    output logic             fbf_reset,
    output logic             result_valid,
    output logic [13:0]      result_data,
    input  logic             result_ready,
    output logic [15:0]      dropped
);
    localparam int TW = $clog2(TIMEOUT);

    seq_state_t    state, state_nxt;
    pitch_result_t res;
    logic [3:0]    decim_cnt;
    logic [TW-1:0] timer;
    logic          synced, frame_start, frame_end;
    logic          start_ok, launch, take_bin, expire, drop;

    frame_position_counter #(.FRAME_LEN(FRAME_LEN)) u_pos (
        .clk         (clk),
        .reset       (reset),
        .beat        (fft_valid),
        .synced      (synced),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    assign start_ok      = (state == IDLE) & frame_start & enable & synced;
    assign fft_ready     = 1'b1;
    assign fbf_bin_ready = 1'b1;
    assign fbf_mag_data  = fft_data;
    // The launching pos==0 beat goes out in the same cycle IDLE decides to forward.
    assign fbf_mag_valid = fft_valid & ((state == FWD) | launch);
    assign fbf_reset     = (state == RECOV);
    assign result_valid  = (state == REPORT);
    assign result_data   = res;

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        take_bin  = 1'b0;
        expire    = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                launch = start_ok & (decim_cnt == 4'd0);
                if (launch) state_nxt = FWD;
            end
            FWD: if (frame_end) state_nxt = WAIT;
            WAIT: begin
                drop     = frame_start;
                take_bin = fbf_bin_valid;
                expire   = !fbf_bin_valid && (timer == TW'(TIMEOUT - 1));
                if (take_bin)    state_nxt = REPORT;
                else if (expire) state_nxt = RECOV;
            end
            RECOV: begin
                drop = frame_start;
                if (timer == TW'(RST_CYC - 1)) state_nxt = REPORT;
            end
            REPORT: begin
                drop = frame_start;
                if (result_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            decim_cnt <= 4'd0;
            timer     <= '0;
            res       <= '0;
            dropped   <= 16'd0;
        end else begin
            state <= state_nxt;
            if (start_ok)
                decim_cnt <= (decim_cnt == 4'd0) ? decim : decim_cnt - 4'd1;
            // timer is shared: WAIT timeout count, then RECOV reset-hold count
            if (state_nxt != state)
                timer <= '0;
            else if (state == WAIT || state == RECOV)
                timer <= timer + 1'b1;
            if (take_bin) begin
                res.timeout <= 1'b0;
                res.bin     <= fbf_bin_data;
            end else if (expire) begin
                res.timeout <= 1'b1;
                res.bin     <= 5'd0;
            end
            if (state == REPORT && result_ready)
                res.frame_id <= res.frame_id + 8'd1;
            if (drop && dropped != 16'hFFFF)
                dropped <= dropped + 16'd1;
        end
    end
endmodule
